// File: rtl/synth_pkg.sv
// Shared constants and types for the MIDI front end of the synth voice path.
package synth_pkg;

  localparam int NUM_VOICES = 8;
  localparam int NOTE_BASE  = 21;
  localparam int NOTE_COUNT = 88;

  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [7:0] MIDI_REALTIME = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NOTE,
    ST_VEL,
    ST_ALLOC
  } parse_state_e;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte FSM with running status; emits one note message per ALLOC cycle.
module midi_msg_parser
  import synth_pkg::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic       i_clk,
  input  logic       i_nreset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic       o_msg_valid,
  output logic       o_msg_on,
  output logic [6:0] o_msg_note,
  output logic [6:0] o_msg_vel
);

  localparam logic [7:0] STATUS_ON  = MIDI_NOTE_ON  | {4'h0, MIDI_CHANNEL};
  localparam logic [7:0] STATUS_OFF = MIDI_NOTE_OFF | {4'h0, MIDI_CHANNEL};

  parse_state_e r_state, w_state;
  logic         r_status_valid, w_status_valid;
  logic         r_status_on, w_status_on;
  logic [6:0]   r_note, w_note;
  logic [6:0]   r_vel, w_vel;
  logic         r_ready;
  logic         w_acc;

  assign w_acc = i_rx_valid & r_ready;

  always_comb begin
    w_state        = r_state;
    w_status_valid = r_status_valid;
    w_status_on    = r_status_on;
    w_note         = r_note;
    w_vel          = r_vel;
    if (r_state == ST_ALLOC) begin
      w_state = ST_NOTE;
    end else if (w_acc && (i_rx_data < MIDI_REALTIME)) begin
      if (i_rx_data[7]) begin
        if (i_rx_data == STATUS_ON || i_rx_data == STATUS_OFF) begin
          w_status_valid = 1'b1;
          w_status_on    = (i_rx_data == STATUS_ON);
          w_state        = ST_NOTE;
        end else begin
          w_status_valid = 1'b0;
          w_state        = ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: if (r_status_valid) begin
            w_note  = i_rx_data[6:0];
            w_state = ST_NOTE;
          end
          ST_NOTE: begin
            w_note  = i_rx_data[6:0];
            w_state = ST_VEL;
          end
          ST_VEL: begin
            w_vel   = i_rx_data[6:0];
            w_state = ST_ALLOC;
          end
          default: ;
        endcase
      end
    end
  end

  // Ready is registered so it stays low through reset and drops exactly for ALLOC.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state        <= ST_IDLE;
      r_status_valid <= 1'b0;
      r_status_on    <= 1'b0;
      r_note         <= '0;
      r_vel          <= '0;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_status_valid <= w_status_valid;
      r_status_on    <= w_status_on;
      r_note         <= w_note;
      r_vel          <= w_vel;
      r_ready        <= (w_state != ST_ALLOC);
    end
  end

  assign o_rx_ready  = r_ready;
  assign o_msg_valid = (r_state == ST_ALLOC);
  assign o_msg_on    = r_status_on && (r_vel != 7'd0);
  assign o_msg_note  = r_note;
  assign o_msg_vel   = r_vel;

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger, lowest free voice, else steal the oldest.
module midi_voice_allocator
  import synth_pkg::*;
#(
  parameter int         NUM_VOICES   = synth_pkg::NUM_VOICES,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int         NOTE_BASE    = synth_pkg::NOTE_BASE,
  parameter int         NOTE_COUNT   = synth_pkg::NOTE_COUNT
) (
  input  logic                          i_clk,
  input  logic                          i_nreset,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_rx_ready,
  input  logic                          i_all_notes_off,
  output logic [NUM_VOICES*7-1:0]       o_voice_note,
  output logic [NUM_VOICES*7-1:0]       o_voice_velocity,
  output logic [NUM_VOICES-1:0]         o_voice_gate,
  output logic [NUM_VOICES-1:0]         o_voice_trig,
  output logic                          o_steal_event,
  output logic [$clog2(NUM_VOICES):0]   o_active_count
);

  localparam int AW = $clog2(NUM_VOICES);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] AGE_MAX = '1;

  logic          w_msg_valid, w_msg_on;
  logic [6:0]    w_msg_note, w_msg_vel;

  logic [6:0]            r_note [NUM_VOICES];
  logic [6:0]            r_vel  [NUM_VOICES];
  logic [AW-1:0]         r_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_gate, r_trig;
  logic                  r_steal;
  logic [CW-1:0]         r_count;

  logic [6:0]            w_note_n [NUM_VOICES];
  logic [6:0]            w_vel_n  [NUM_VOICES];
  logic [AW-1:0]         w_age_n  [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_gate_n, w_trig_n;
  logic                  w_steal_n;
  logic [CW-1:0]         w_count_n;

  logic [7:0]    w_note_ext;
  logic          w_in_range;
  logic [6:0]    w_idx;
  logic          w_match_hit, w_free_hit;
  logic [AW-1:0] w_match_idx, w_free_idx, w_old_idx, w_old_age, w_sel;

  midi_msg_parser #(.MIDI_CHANNEL(MIDI_CHANNEL)) u_parser (
    .i_clk       (i_clk),
    .i_nreset    (i_nreset),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_msg_valid (w_msg_valid),
    .o_msg_on    (w_msg_on),
    .o_msg_note  (w_msg_note),
    .o_msg_vel   (w_msg_vel)
  );

  assign w_note_ext = {1'b0, w_msg_note};
  assign w_in_range = (w_note_ext >= 8'(NOTE_BASE)) && (w_note_ext < 8'(NOTE_BASE + NOTE_COUNT));
  assign w_idx      = 7'(w_note_ext - 8'(NOTE_BASE));

  // Descending scans leave the lowest matching index; the oldest scan keeps the first maximum.
  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    w_old_idx   = '0;
    w_old_age   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_gate[i] && (r_note[i] == w_idx)) begin
        w_match_hit = 1'b1;
        w_match_idx = AW'(i);
      end
      if (!r_gate[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = AW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = AW'(i);
      end
    end
    w_sel = w_match_hit ? w_match_idx : (w_free_hit ? w_free_idx : w_old_idx);
  end

  always_comb begin
    w_note_n  = r_note;
    w_vel_n   = r_vel;
    w_age_n   = r_age;
    w_gate_n  = r_gate;
    w_trig_n  = '0;
    w_steal_n = 1'b0;
    w_count_n = '0;
    if (i_all_notes_off) begin
      w_gate_n = '0;
    end else if (w_msg_valid && w_in_range) begin
      if (w_msg_on) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_gate[i] && (AW'(i) != w_sel) && (r_age[i] != AGE_MAX))
            w_age_n[i] = r_age[i] + 1'b1;
        end
        w_note_n[w_sel] = w_idx;
        w_vel_n[w_sel]  = w_msg_vel;
        w_age_n[w_sel]  = '0;
        w_gate_n[w_sel] = 1'b1;
        w_trig_n[w_sel] = 1'b1;
        w_steal_n       = !w_match_hit && !w_free_hit;
      end else begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_note[i] == w_idx) w_gate_n[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) w_count_n = w_count_n + CW'(w_gate_n[i]);
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_age[i]  <= '0;
      end
      r_gate  <= '0;
      r_trig  <= '0;
      r_steal <= 1'b0;
      r_count <= '0;
    end else begin
      r_note  <= w_note_n;
      r_vel   <= w_vel_n;
      r_age   <= w_age_n;
      r_gate  <= w_gate_n;
      r_trig  <= w_trig_n;
      r_steal <= w_steal_n;
      r_count <= w_count_n;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
    assign o_voice_note[7*gi +: 7]     = r_note[gi];
    assign o_voice_velocity[7*gi +: 7] = r_vel[gi];
  end

  assign o_voice_gate   = r_gate;
  assign o_voice_trig   = r_trig;
  assign o_steal_event  = r_steal;
  assign o_active_count = r_count;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with a scoreboard of predicted voice state.
module tb_midi_voice_allocator;

  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          all_notes_off = 1'b0;
  logic          rx_ready;
  logic [NV*7-1:0] voice_note, voice_velocity;
  logic [NV-1:0] voice_gate, voice_trig;
  logic          steal_event;
  logic [3:0]    active_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  midi_voice_allocator #(
    .NUM_VOICES(NV), .MIDI_CHANNEL(4'd0), .NOTE_BASE(21), .NOTE_COUNT(88)
  ) dut (
    .i_clk            (clk),
    .i_nreset         (nreset),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_rx_ready       (rx_ready),
    .i_all_notes_off  (all_notes_off),
    .o_voice_note     (voice_note),
    .o_voice_velocity (voice_velocity),
    .o_voice_gate     (voice_gate),
    .o_voice_trig     (voice_trig),
    .o_steal_event    (steal_event),
    .o_active_count   (active_count)
  );

  typedef struct {
    string           tag;
    logic [NV*7-1:0] note;
    logic [NV*7-1:0] vel;
    logic [NV-1:0]   gate;
    logic [NV-1:0]   trig;
    logic            steal;
    logic [3:0]      cnt;
  } exp_t;

  exp_t exp_q[$];

  int         m_note [NV];
  int         m_vel  [NV];
  int         m_age  [NV];
  bit         m_gate [NV];
  logic [NV-1:0] m_trig;
  bit         m_steal;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 0;
    end
    m_trig = '0; m_steal = 0;
  endfunction

  function automatic void push_expect(input string tag);
    exp_t e;
    int n = 0;
    e.tag = tag;
    for (int i = 0; i < NV; i++) begin
      e.note[7*i +: 7] = 7'(m_note[i]);
      e.vel[7*i +: 7]  = 7'(m_vel[i]);
      e.gate[i]        = m_gate[i];
      n += int'(m_gate[i]);
    end
    e.trig  = m_trig;
    e.steal = m_steal;
    e.cnt   = 4'(n);
    exp_q.push_back(e);
  endfunction

  // Reference behaviour: retrigger held note, else lowest free voice, else oldest voice.
  function automatic void model_msg(input string tag, input bit on, input int midi_note, input int vel);
    int idx, sel;
    bit found;
    m_trig = '0; m_steal = 0;
    if (midi_note >= 21 && midi_note < 109) begin
      idx = midi_note - 21;
      if (on && vel != 0) begin
        found = 0; sel = 0;
        for (int i = 0; i < NV; i++)
          if (!found && m_gate[i] && m_note[i] == idx) begin found = 1; sel = i; end
        for (int i = 0; i < NV; i++)
          if (!found && !m_gate[i]) begin found = 1; sel = i; end
        if (!found) begin
          m_steal = 1;
          for (int i = 1; i < NV; i++) if (m_age[i] > m_age[sel]) sel = i;
        end
        for (int i = 0; i < NV; i++)
          if (m_gate[i] && i != sel && m_age[i] < 7) m_age[i]++;
        m_note[sel] = idx; m_vel[sel] = vel; m_gate[sel] = 1; m_age[sel] = 0;
        m_trig[sel] = 1'b1;
      end else begin
        for (int i = 0; i < NV; i++) if (m_note[i] == idx) m_gate[i] = 0;
      end
    end
    push_expect(tag);
  endfunction

  function automatic void model_panic(input string tag);
    for (int i = 0; i < NV; i++) m_gate[i] = 0;
    m_trig = '0; m_steal = 0;
    push_expect(tag);
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 20) begin @(negedge clk); n++; end
    chk("rx_ready_before_byte", rx_ready, 1'b1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Called right after the velocity byte: ALLOC cycle, commit cycle, then pulse clear.
  task automatic check_commit(input bit panic);
    exp_t e;
    @(negedge clk);
    chk("rx_ready_in_alloc", rx_ready, 1'b0);
    if (panic) all_notes_off = 1'b1;
    @(negedge clk);
    all_notes_off = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_note"},  voice_note,     e.note);
      chk({e.tag, "_vel"},   voice_velocity, e.vel);
      chk({e.tag, "_gate"},  voice_gate,     e.gate);
      chk({e.tag, "_trig"},  voice_trig,     e.trig);
      chk({e.tag, "_steal"}, steal_event,    e.steal);
      chk({e.tag, "_count"}, active_count,   e.cnt);
      chk({e.tag, "_ready"}, rx_ready,       1'b1);
      $display("txn %s gate=%0h trig=%0h steal=%0b count=%0d", e.tag, voice_gate, voice_trig, steal_event, active_count);
    end
    @(negedge clk);
    chk("trig_one_cycle",  voice_trig,  '0);
    chk("steal_one_cycle", steal_event, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("reset_gate",  voice_gate,     '0);
    chk("reset_note",  voice_note,     '0);
    chk("reset_vel",   voice_velocity, '0);
    chk("reset_count", active_count,   '0);
    chk("reset_ready", rx_ready,       1'b0);
    @(negedge clk);
    nreset = 1'b1;
    #1 chk("ready_before_first_clk", rx_ready, 1'b0);
    @(posedge clk);
    #1 chk("ready_after_first_clk", rx_ready, 1'b1);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Basic note-on lands on voice 0.
    do_reset();
    send(8'h90); send(8'h3C);
    model_msg("t1_on3C", 1, 8'h3C, 8'h64);
    send(8'h64); check_commit(0);
    chk("t1_voice0_note", voice_note[6:0], 7'd39);

    // Running status note-on, then note-off and velocity-0 note-off.
    send(8'h40);
    model_msg("t2_on40", 1, 8'h40, 8'h50);
    send(8'h50); check_commit(0);
    chk("t2_voice1_note", voice_note[13:7], 7'd43);
    send(8'h80); send(8'h3C);
    model_msg("t2_off3C", 0, 8'h3C, 0);
    send(8'h00); check_commit(0);
    chk("t2_note_retained", voice_note[6:0], 7'd39);
    send(8'h90); send(8'h40);
    model_msg("t2_vel0_off", 1, 8'h40, 0);
    send(8'h00); check_commit(0);

    // Nine held notes: the ninth steals the oldest (voice 0).
    do_reset();
    send(8'h90);
    for (int k = 0; k < 9; k++) begin
      send(8'(8'h3C + k));
      model_msg($sformatf("t3_on%0d", k), 1, 8'h3C + k, 8'h64);
      send(8'h64); check_commit(0);
    end
    chk("t3_stolen_note", voice_note[6:0], 7'd47);

    // Retrigger of a held note reuses the same voice.
    do_reset();
    send(8'h90); send(8'h3C);
    model_msg("t4_first", 1, 8'h3C, 8'h64);
    send(8'h64); check_commit(0);
    send(8'h90); send(8'h3C);
    model_msg("t4_retrig", 1, 8'h3C, 8'h20);
    send(8'h20); check_commit(0);
    chk("t4_retrig_vel", voice_velocity[6:0], 7'd32);

    // Realtime bytes interleaved mid-message are ignored.
    do_reset();
    send(8'h90); send(8'hF8);
    chk("t5_ready_after_rt", rx_ready, 1'b1);
    send(8'h3C); send(8'hFE);
    model_msg("t5_rt", 1, 8'h3C, 8'h64);
    send(8'h64); check_commit(0);

    // Panic during ALLOC discards the commit and clears every gate.
    send(8'h90); send(8'h48);
    model_panic("t6_panic");
    send(8'h64); check_commit(1);

    // Out-of-range note commits nothing.
    send(8'h05);
    model_msg("t6_out_of_range", 1, 8'h05, 8'h40);
    send(8'h40); check_commit(0);

    // Asynchronous reset mid-message clears outputs immediately.
    send(8'h90); send(8'h3C);
    #2 nreset = 1'b0;
    #1;
    chk("t7_async_note",  voice_note,     '0);
    chk("t7_async_vel",   voice_velocity, '0);
    chk("t7_async_ready", rx_ready,       1'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1 chk("t7_ready_after_release", rx_ready, 1'b1);
    model_reset();
    send(8'h90); send(8'h3C);
    model_msg("t7_recover", 1, 8'h3C, 8'h64);
    send(8'h64); check_commit(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Parses the SPI-received MIDI byte stream (note-on/note-off) and assigns notes to NUM_VOICES oscillator voices.
- Drives per-voice note index, gate, velocity and trigger to the phase accumulators and envelope generators.
- Replaces ad-hoc voice assignment with one-clock, deterministic allocation that includes retrigger and oldest-voice stealing.

Parameters:
- NUM_VOICES, 8, number of voices (power of 2, 2..16).
- MIDI_CHANNEL, 0, accepted channel nibble for 0x9n/0x8n.
- NOTE_BASE, 21, MIDI note mapped to note-table index 0.
- NOTE_COUNT, 88, number of valid note-table entries.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- rx_data  in  8  received MIDI byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid&rx_ready.
- all_notes_off  in  1  synchronous panic: clear all gates.
- voice_note  out  NUM_VOICES*7  packed note-table index per voice (voice i at [7i+6:7i]).
- voice_velocity  out  NUM_VOICES*7  packed velocity per voice.
- voice_gate  out  NUM_VOICES  1 = key held.
- voice_trig  out  NUM_VOICES  one-cycle pulse on (re)trigger.
- steal_event  out  1  one-cycle pulse when an active voice was stolen.
- active_count  out  clog2(NUM_VOICES)+1  number of gated voices.

Behaviour:
- Reset (async, nreset=0): FSM=IDLE, running status cleared, all ages 0. All outputs 0, except rx_ready=1 from the first clock after reset release.
- FSM states: IDLE (await status), NOTE (await byte 1), VEL (await byte 2), ALLOC (one commit cycle).
- Realtime bytes 0xF8-0xFF are accepted and ignored in every state; the state is unchanged.
- Any status byte (bit7=1, not realtime) in any non-ALLOC state:
  - If it is 0x90|MIDI_CHANNEL or 0x80|MIDI_CHANNEL: latch it as running status and go to NOTE.
  - Otherwise: clear running status and go to IDLE.
- Data byte (bit7=0) handling:
  - IDLE: go to NOTE if running status is valid, storing the byte as the note; else drop the byte.
  - NOTE: store the note, go to VEL.
  - VEL: store the velocity, go to ALLOC.
- rx_ready=0 only during ALLOC. ALLOC always returns to NOTE, because running status is kept.
- Latency: the velocity byte accepted in cycle N puts the FSM in ALLOC at N+1. Updated outputs and pulses are visible at N+2.
- Note outside NOTE_BASE..NOTE_BASE+NOTE_COUNT-1: ALLOC commits nothing.
- Note-on (0x9n) with velocity 0 is treated as note-off.
- Note-on commit, evaluated in priority order:
  - If a gated voice already holds the note: retrigger it (update velocity, trig pulse, age:=0).
  - Else the lowest-index voice with gate=0 gets note, velocity, gate=1, trig.
  - Else steal the voice with the largest age (ties go to the lowest index): overwrite it, trig, steal_event=1.
- Ages: per-voice counter, width clog2(NUM_VOICES). On each note-on commit the chosen voice age:=0 and every other gated voice age saturating-increments.
- Note-off commit: gate:=0 on every voice holding that note. Note and velocity are retained for the release stage. No trig is issued. Ages are unchanged.
- all_notes_off: in the next cycle all gates=0. It has priority over a same-cycle ALLOC, whose commit is discarded. The FSM still returns to NOTE.
- active_count is registered and consistent with voice_gate in the same cycle.
- voice_trig and steal_event are high for exactly one cycle per commit.

Decomposition:
- synth_pkg holds:
  - NUM_VOICES, NOTE_BASE, NOTE_COUNT.
  - MIDI_NOTE_ON=8'h90, MIDI_NOTE_OFF=8'h80, realtime threshold 8'hF8.
  - Parser state enum {IDLE, NOTE, VEL, ALLOC}.
- One sub-module, midi_msg_parser: byte FSM with running status. Outputs a one-cycle msg_valid with msg_on, msg_note and msg_vel. Voice selection (match / free / oldest) stays in the top level as combinational priority logic.

Test Plan:
- Reset, then bytes 90 3C 64 → at N+2: voice0 note=39, velocity=100, gate=1; trig[0] pulses; active_count=1.
- Bytes 90 3C 64 40 50 (running status) → voice1 note=43, velocity=80; 80 3C 00 → gate[0]=0, voice_note[0] still 39.
- Nine note-ons 3C..44 with no note-offs → the ninth goes to voice0 (oldest, age 7); steal_event=1; active_count stays 8.
- 90 3C 64 then 90 3C 20 → same voice retriggered with velocity=32; no second voice used; trig pulses twice.
- Bytes 90 F8 3C FE 64 → treated as 90 3C 64; rx_ready=0 only during the ALLOC cycle.
- all_notes_off asserted during the ALLOC cycle of 90 48 64 → all gates 0, no trig; a note byte 05 (outside range) commits nothing; nreset asserted mid-message → outputs 0 immediately.
